// File: rtl/jelly_stream_syncflag_gen_pkg.sv
// Shared types for the sync-flag token generator.
// Holds the controller state encoding.
package jelly_stream_syncflag_gen_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/jelly_stream_syncflag_gen.sv
// Emits one sync-flag token per packet of a group, with first/last flags,
// packet index and a wrapping group counter, stopping only at group boundaries.
module jelly_stream_syncflag_gen
   import jelly_stream_syncflag_gen_pkg::*;
#(
   parameter int          INDEX_WIDTH = 16,
   parameter int          GROUP_WIDTH = 8,
   parameter int unsigned INIT_GROUP  = 0
)
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cke,

   input  logic                   enable,
   output logic                   busy,

   input  logic [INDEX_WIDTH-1:0] param_num,

   output logic                   m_first,
   output logic                   m_last,
   output logic [INDEX_WIDTH-1:0] m_index,
   output logic [GROUP_WIDTH-1:0] m_group,
   output logic                   m_valid,
   input  logic                   m_ready
);

   localparam logic [INDEX_WIDTH-1:0] IndexOne  = INDEX_WIDTH'(1);
   localparam logic [GROUP_WIDTH-1:0] GroupOne  = GROUP_WIDTH'(1);
   localparam logic [GROUP_WIDTH-1:0] GroupInit = GROUP_WIDTH'(INIT_GROUP);

   state_e                 state_q, state_d;
   logic [INDEX_WIDTH-1:0] num_q, num_d;
   logic [INDEX_WIDTH-1:0] index_q, index_d;
   logic [GROUP_WIDTH-1:0] group_q, group_d;
   logic                   first_q, first_d;
   logic                   last_q, last_d;
   logic                   valid_q, valid_d;
   logic                   busy_q, busy_d;

   logic [INDEX_WIDTH-1:0] numSafe;
   logic [INDEX_WIDTH-1:0] indexNext;
   logic [INDEX_WIDTH-1:0] numMinusOne;
   logic                   startGroup;
   logic                   stopRun;

   // A zero packet count is treated as a single-packet group.
   assign numSafe     = (param_num == '0) ? IndexOne : param_num;
   assign indexNext   = index_q + IndexOne;
   assign numMinusOne = num_q - IndexOne;

   always_comb begin
      state_d    = state_q;
      num_d      = num_q;
      index_d    = index_q;
      group_d    = group_q;
      first_d    = first_q;
      last_d     = last_q;
      valid_d    = valid_q;
      busy_d     = busy_q;
      startGroup = 1'b0;
      stopRun    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               startGroup = 1'b1;
            end
         end
         ST_RUN: begin
            if (m_ready) begin
               if (!last_q) begin
                  index_d = indexNext;
                  first_d = 1'b0;
                  last_d  = (indexNext == numMinusOne);
               end else begin
                  group_d = group_q + GroupOne;
                  if (enable) begin
                     startGroup = 1'b1;
                  end else begin
                     stopRun = 1'b1;
                  end
               end
            end
         end
         default: begin
            stopRun = 1'b1;
         end
      endcase

      // The packet count is only ever captured here, so mid-group changes wait.
      if (startGroup) begin
         state_d = ST_RUN;
         num_d   = numSafe;
         index_d = '0;
         first_d = 1'b1;
         last_d  = (numSafe == IndexOne);
         valid_d = 1'b1;
         busy_d  = 1'b1;
      end

      if (stopRun) begin
         state_d = ST_IDLE;
         first_d = 1'b0;
         last_d  = 1'b0;
         valid_d = 1'b0;
         busy_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         num_q   <= IndexOne;
         index_q <= '0;
         group_q <= GroupInit;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else if (cke) begin
         state_q <= state_d;
         num_q   <= num_d;
         index_q <= index_d;
         group_q <= group_d;
         first_q <= first_d;
         last_q  <= last_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign busy    = busy_q;
   assign m_first = first_q;
   assign m_last  = last_q;
   assign m_index = index_q;
   assign m_group = group_q;
   assign m_valid = valid_q;

endmodule

// File: tb/tb_jelly_stream_syncflag_gen.sv
// Directed bench for the sync-flag token generator using a 4-bit index
// so the full-range packet count is reachable in a few cycles.
module tb_jelly_stream_syncflag_gen;

   localparam int IW = 4;
   localparam int GW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          cke;
   logic          enable;
   logic          busy;
   logic [IW-1:0] param_num;
   logic          m_first;
   logic          m_last;
   logic [IW-1:0] m_index;
   logic [GW-1:0] m_group;
   logic          m_valid;
   logic          m_ready;

   int vectors = 0;
   int errors  = 0;

   jelly_stream_syncflag_gen #(
      .INDEX_WIDTH(IW),
      .GROUP_WIDTH(GW),
      .INIT_GROUP (0)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .cke      (cke),
      .enable   (enable),
      .busy     (busy),
      .param_num(param_num),
      .m_first  (m_first),
      .m_last   (m_last),
      .m_index  (m_index),
      .m_group  (m_group),
      .m_valid  (m_valid),
      .m_ready  (m_ready)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Observed layout: {busy, valid, first, last, index, group}
   task automatic checkFull(input string tag, input logic [15:0] expected);
      logic [15:0] observed;
      observed = {busy, m_valid, m_first, m_last, m_index, m_group};
      vectors++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkTok(input string tag, input logic eF, input logic eL,
                           input int eI, input int eG);
      checkFull(tag, {1'b1, 1'b1, eF, eL, IW'(eI), GW'(eG)});
   endtask

   task automatic checkIdle(input string tag, input int eG);
      logic [9:0] observed;
      logic [9:0] expected;
      observed = {busy, m_valid, m_group};
      expected = {2'b00, GW'(eG)};
      vectors++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      reset     = 1'b1;
      cke       = 1'b1;
      enable    = 1'b0;
      m_ready   = 1'b0;
      param_num = 4'd4;
      tick();
      tick();
      reset = 1'b0;
      checkFull("reset", 16'h0000);

      // Two back-to-back groups of four, no bubble at the boundary
      enable  = 1'b1;
      m_ready = 1'b1;
      for (int g = 0; g < 2; g++) begin
         for (int i = 0; i < 4; i++) begin
            tick();
            checkTok("basic", i == 0, i == 3, i, g);
         end
      end

      // Enable drops at index 1; the group still completes
      tick();
      checkTok("stop_i0", 1'b1, 1'b0, 0, 2);
      tick();
      checkTok("stop_i1", 1'b0, 1'b0, 1, 2);
      enable = 1'b0;
      tick();
      checkTok("stop_i2", 1'b0, 1'b0, 2, 2);
      tick();
      checkTok("stop_i3", 1'b0, 1'b1, 3, 2);
      tick();
      checkIdle("stop_idle", 3);
      tick();
      checkIdle("stop_idle2", 3);

      // cke low in idle blocks startup
      enable = 1'b1;
      cke    = 1'b0;
      tick();
      checkIdle("cke_idle", 3);

      // Backpressure and cke hold, then last accept with enable falling
      cke       = 1'b1;
      param_num = 4'd2;
      m_ready   = 1'b0;
      tick();
      checkTok("bp_start", 1'b1, 1'b0, 0, 3);
      tick();
      checkTok("bp_hold", 1'b1, 1'b0, 0, 3);
      m_ready = 1'b1;
      cke     = 1'b0;
      tick();
      checkTok("cke_hold", 1'b1, 1'b0, 0, 3);
      tick();
      checkTok("cke_hold2", 1'b1, 1'b0, 0, 3);
      cke = 1'b1;
      tick();
      checkTok("bp_i1", 1'b0, 1'b1, 1, 3);
      m_ready = 1'b0;
      tick();
      checkTok("bp_hold_last", 1'b0, 1'b1, 1, 3);
      m_ready = 1'b1;
      enable  = 1'b0;
      tick();
      checkIdle("last_and_stop", 4);

      // Single-packet groups, including a zero count treated as one
      param_num = 4'd1;
      enable    = 1'b1;
      tick();
      checkTok("num1_a", 1'b1, 1'b1, 0, 4);
      tick();
      checkTok("num1_b", 1'b1, 1'b1, 0, 5);
      param_num = 4'd0;
      tick();
      checkTok("num0_a", 1'b1, 1'b1, 0, 6);
      tick();
      checkTok("num0_b", 1'b1, 1'b1, 0, 7);
      for (int k = 8; k <= 260; k++) begin
         tick();
         checkTok("group_wrap", 1'b1, 1'b1, 0, k % 256);
      end

      // Count change mid-group only takes effect at the next group
      param_num = 4'd3;
      tick();
      checkTok("relatch_g5_0", 1'b1, 1'b0, 0, 5);
      tick();
      checkTok("relatch_g5_1", 1'b0, 1'b0, 1, 5);
      param_num = 4'd6;
      tick();
      checkTok("relatch_g5_2", 1'b0, 1'b1, 2, 5);
      for (int i = 0; i < 6; i++) begin
         tick();
         checkTok("relatch_g6", i == 0, i == 5, i, 6);
      end

      // Reset at index 2 of group 7 abandons the group
      tick();
      checkTok("pre_reset_0", 1'b1, 1'b0, 0, 7);
      tick();
      tick();
      checkTok("pre_reset_2", 1'b0, 1'b0, 2, 7);
      reset = 1'b1;
      tick();
      checkFull("mid_reset", 16'h0000);
      reset = 1'b0;
      tick();
      checkTok("restart", 1'b1, 1'b0, 0, 0);

      // Full-range count: 15 packets gives index 0..14
      param_num = 4'd15;
      for (int i = 1; i < 6; i++) begin
         tick();
         checkTok("restart_g0", 1'b0, i == 5, i, 0);
      end
      for (int i = 0; i < 15; i++) begin
         tick();
         checkTok("max_num", i == 0, i == 14, i, 1);
      end
      tick();
      checkTok("max_next", 1'b1, 1'b0, 0, 2);
      enable = 1'b0;
      for (int i = 1; i < 15; i++) begin
         tick();
      end
      checkTok("max_drain_last", 1'b0, 1'b1, 14, 2);
      tick();
      checkIdle("max_idle", 3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
